// File: rtl/alu_uart_ctrl.sv
// alu_uart_ctrl: collects opcode/A/B bytes from the UART receiver, drives the
// ALU, captures the result and starts one transmit of the result byte.
// Ports: i_clk, i_reset (sync, active-high), i_rx_done/i_rx_data (rx byte),
//   i_alu_result (ALU out), i_tx_done (tx finished), o_alu_a/o_alu_b/o_alu_op
//   (ALU operands), o_tx_start/o_tx_data (tx request), o_busy (frame in
//   progress), o_timeout_err (partial frame dropped).
module alu_uart_ctrl #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_timeout_err
);

  localparam int NB_CNT =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [NB_CNT-1:0] CNT_MAX =
    NB_CNT'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_OP,
    WAIT_A,
    WAIT_B,
    EXEC,
    SEND,
    WAIT_TX
  } state_t;

  state_t              state_q, state_d;
  logic [NB_DATA-1:0]  a_q, a_d;
  logic [NB_DATA-1:0]  b_q, b_d;
  logic [NB_OP-1:0]    op_q, op_d;
  logic [NB_DATA-1:0]  tx_data_q, tx_data_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic                err_q, err_d;

  // Opcode byte upper bits carry no meaning for the ALU.
  logic rx_unused;
  assign rx_unused = ^i_rx_data[NB_DATA-1:NB_OP];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    tx_data_d = tx_data_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    unique case (state_q)
      WAIT_OP: begin
        if (i_rx_done) begin
          op_d    = i_rx_data[NB_OP-1:0];
          cnt_d   = '0;
          state_d = WAIT_A;
        end
      end
      WAIT_A: begin
        if (i_rx_done) begin
          a_d     = i_rx_data;
          cnt_d   = '0;
          state_d = WAIT_B;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = WAIT_OP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_B: begin
        if (i_rx_done) begin
          b_d     = i_rx_data;
          cnt_d   = '0;
          state_d = EXEC;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = WAIT_OP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EXEC: begin
        tx_data_d = i_alu_result;
        state_d   = SEND;
      end
      SEND: begin
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) begin
          state_d = WAIT_OP;
        end
      end
      default: begin
        state_d = WAIT_OP;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= WAIT_OP;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      tx_data_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      tx_data_q <= tx_data_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign o_alu_a       = a_q;
  assign o_alu_b       = b_q;
  assign o_alu_op      = op_q;
  assign o_tx_data     = tx_data_q;
  assign o_tx_start    = (state_q == SEND);
  assign o_busy        = (state_q != WAIT_OP);
  assign o_timeout_err = err_q;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// tb_alu_uart_ctrl: directed plus randomized frames for alu_uart_ctrl,
// checked against a frame-level reference model with a small ALU stand-in.
module tb_alu_uart_ctrl;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int TO      = 16;

  logic               i_clk = 1'b0;
  logic               i_reset;
  logic               i_rx_done;
  logic [NB_DATA-1:0] i_rx_data;
  logic [NB_DATA-1:0] i_alu_result;
  logic               i_tx_done;
  logic [NB_DATA-1:0] o_alu_a;
  logic [NB_DATA-1:0] o_alu_b;
  logic [NB_OP-1:0]   o_alu_op;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_busy;
  logic               o_timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0] m_op;
  logic [7:0] m_a, m_b, m_tx;

  logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25,
                          6'h26, 6'h27, 6'h02, 6'h03};

  alu_uart_ctrl #(
    .NB_DATA(NB_DATA),
    .NB_OP(NB_OP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_rx_done(i_rx_done),
    .i_rx_data(i_rx_data),
    .i_alu_result(i_alu_result),
    .i_tx_done(i_tx_done),
    .o_alu_a(o_alu_a),
    .o_alu_b(o_alu_b),
    .o_alu_op(o_alu_op),
    .o_tx_start(o_tx_start),
    .o_tx_data(o_tx_data),
    .o_busy(o_busy),
    .o_timeout_err(o_timeout_err)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] alu_f(
    input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h02: return a >> b[2:0];
      6'h03: return 8'($signed(a) >>> b[2:0]);
      default: return 8'h00;
    endcase
  endfunction

  assign i_alu_result = alu_f(o_alu_op, o_alu_a, o_alu_b);

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
    i_rx_data = 8'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_err", o_timeout_err, 0);
      chk("idle_start", o_tx_start, 0);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_op"}, o_alu_op, m_op);
    chk({tag, "_a"}, o_alu_a, m_a);
    chk({tag, "_b"}, o_alu_b, m_b);
  endtask

  task automatic run_frame(input logic [7:0] op8,
                           input logic [7:0] a,
                           input logic [7:0] b,
                           input int gap);
    send(op8);
    m_op = op8[5:0];
    chk("f_op", o_alu_op, m_op);
    chk("f_busy_a", o_busy, 1);
    idle(gap);
    send(a);
    m_a = a;
    chk("f_a", o_alu_a, m_a);
    idle(gap);
    send(b);
    m_b = b;
    m_tx = alu_f(m_op, a, b);
    chk_regs("f_exec");
    chk("f_exec_start", o_tx_start, 0);
    tick();
    chk("f_start", o_tx_start, 1);
    chk("f_data", o_tx_data, m_tx);
    tick();
    chk("f_start_end", o_tx_start, 0);
    chk("f_busy_tx", o_busy, 1);
    chk("f_data_hold", o_tx_data, m_tx);
  endtask

  task automatic finish_tx(input int wait_n, input bit drop);
    if (drop) begin
      send(8'h55);
      chk_regs("drop");
      chk("drop_busy", o_busy, 1);
    end
    idle(wait_n);
    chk("tx_busy", o_busy, 1);
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    chk("tx_idle", o_busy, 0);
    chk("tx_data_keep", o_tx_data, m_tx);
  endtask

  task automatic partial(input int nb, input logic [7:0] op8,
                         input logic [7:0] a);
    send(op8);
    m_op = op8[5:0];
    if (nb == 2) begin
      send(a);
      m_a = a;
    end
    for (int i = 1; i <= TO; i++) begin
      tick();
      chk("to_err", o_timeout_err, (i == TO) ? 1 : 0);
      chk("to_busy", o_busy, (i == TO) ? 0 : 1);
      chk("to_start", o_tx_start, 0);
    end
    tick();
    chk("to_err_end", o_timeout_err, 0);
    chk_regs("to_hold");
    chk("to_txdata", o_tx_data, m_tx);
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_a"}, o_alu_a, 0);
    chk({tag, "_b"}, o_alu_b, 0);
    chk({tag, "_op"}, o_alu_op, 0);
    chk({tag, "_data"}, o_tx_data, 0);
    chk({tag, "_start"}, o_tx_start, 0);
    chk({tag, "_err"}, o_timeout_err, 0);
    chk({tag, "_busy"}, o_busy, 0);
  endtask

  task automatic do_reset;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    m_op = '0;
    m_a  = '0;
    m_b  = '0;
    m_tx = '0;
  endtask

  initial begin
    i_reset   = 1'b1;
    i_rx_done = 1'b0;
    i_rx_data = '0;
    i_tx_done = 1'b0;
    tick();
    tick();
    do_reset();
    zero_check("reset");

    // basic ADD frame
    run_frame(8'h20, 8'h05, 8'h03, 0);
    chk("basic_sum", o_tx_data, 8'h08);
    finish_tx(3, 1'b0);

    // opcode masking with SUB
    run_frame(8'hE2, 8'h0F, 8'h05, 2);
    chk("mask_op", o_alu_op, 6'h22);
    chk("mask_sub", o_tx_data, 8'h0A);
    finish_tx(1, 1'b0);

    // stray tx_done outside WAIT_TX is ignored
    send(8'h26);
    m_op = 6'h26;
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    chk("stray_txd_busy", o_busy, 1);
    send(8'h33);
    m_a = 8'h33;
    send(8'h0F);
    m_b = 8'h0F;
    m_tx = 8'h3C;
    tick();
    chk("stray_start", o_tx_start, 1);
    chk("stray_xor", o_tx_data, 8'h3C);
    tick();
    finish_tx(0, 1'b0);

    // timeout after two bytes, then a clean AND frame
    partial(2, 8'h20, 8'h05);
    run_frame(8'h24, 8'hF0, 8'h3C, 0);
    chk("to_and", o_tx_data, 8'h30);
    finish_tx(2, 1'b0);

    // timeout boundary: bytes land on the last allowed cycle
    run_frame(8'h25, 8'hA0, 8'h05, TO - 1);
    chk("bound_or", o_tx_data, 8'hA5);
    finish_tx(1, 1'b0);

    // byte during WAIT_TX is dropped
    run_frame(8'h20, 8'h10, 8'h20, 1);
    finish_tx(2, 1'b1);
    run_frame(8'h22, 8'h10, 8'h01, 0);
    chk("after_drop", o_tx_data, 8'h0F);
    finish_tx(0, 1'b0);

    // reset while waiting for transmit completion
    run_frame(8'h26, 8'hFF, 8'h0F, 0);
    idle(2);
    do_reset();
    zero_check("rst_tx");
    idle(4);
    chk("rst_tx_idle", o_busy, 0);
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    zero_check("rst_txdone");

    // reset mid-frame
    send(8'h20);
    send(8'h77);
    do_reset();
    zero_check("rst_frame");

    // randomized frames
    for (int it = 0; it < 24; it++) begin
      logic [7:0] op8, a, b;
      op8 = {2'($urandom), ops[$urandom_range(0, 7)]};
      a   = 8'($urandom);
      b   = 8'($urandom);
      if (it % 5 == 2) begin
        partial($urandom_range(1, 2), 8'($urandom), 8'($urandom));
      end
      run_frame(op8, a, b, $urandom_range(0, TO - 1));
      finish_tx($urandom_range(0, 6), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_uart_ctrl.md
Name: alu_uart_ctrl

Overview:
Command sequencer between the UART receiver/transmitter and the combinational ALU on the Basys3 design. It collects a 3-byte command frame from the receiver (opcode, operand A, operand B), drives the ALU inputs, captures the result and hands one result byte to the UART transmitter. An inter-byte timeout resynchronises the frame if the host stalls mid-command.

Parameters:
NB_DATA, 8, width of UART bytes, ALU operands and result
NB_OP, 6, ALU opcode width; taken from opcode byte bits [NB_OP-1:0]
TIMEOUT_CYCLES, 100000000, i_clk cycles allowed between frame bytes (1 s at 100 MHz); counter width $clog2(TIMEOUT_CYCLES)

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_rx_done  in  1  one-cycle pulse: i_rx_data holds a new received byte
i_rx_data  in  NB_DATA  received byte, valid when i_rx_done=1
i_alu_result  in  NB_DATA  combinational ALU result for o_alu_a/o_alu_b/o_alu_op
i_tx_done  in  1  one-cycle pulse from transmitter: byte fully sent
o_alu_a  out  NB_DATA  registered operand A
o_alu_b  out  NB_DATA  registered operand B
o_alu_op  out  NB_OP  registered opcode
o_tx_start  out  1  one-cycle pulse: start transmitting o_tx_data
o_tx_data  out  NB_DATA  registered result byte, stable from o_tx_start until i_tx_done
o_busy  out  1  high in every state except WAIT_OP
o_timeout_err  out  1  one-cycle pulse when a partial frame is discarded

Behaviour:
- Reset: state=WAIT_OP; o_alu_a, o_alu_b, o_alu_op, o_tx_data = 0; o_tx_start=0; o_timeout_err=0; o_busy=0; timeout counter=0.
- States: WAIT_OP, WAIT_A, WAIT_B, EXEC, SEND, WAIT_TX.
- WAIT_OP: on i_rx_done, o_alu_op <= i_rx_data[NB_OP-1:0] (upper bits ignored), clear counter, go WAIT_A.
- WAIT_A: on i_rx_done, o_alu_a <= i_rx_data, clear counter, go WAIT_B.
- WAIT_B: on i_rx_done, o_alu_b <= i_rx_data, go EXEC.
- In WAIT_A/WAIT_B without i_rx_done: counter increments; when counter == TIMEOUT_CYCLES-1, go WAIT_OP, clear counter, pulse o_timeout_err for exactly one cycle. i_rx_done in that same cycle wins: the byte is accepted, no timeout.
- Partial frame discard leaves o_alu_* holding the last written values; no transmission.
- EXEC: exactly one cycle; ALU inputs are stable since WAIT_B exit; at end of EXEC o_tx_data <= i_alu_result; go SEND.
- SEND: o_tx_start=1 for this single cycle; go WAIT_TX.
- WAIT_TX: hold; on i_tx_done go WAIT_OP. No timeout in WAIT_TX.
- Latency: last operand byte's i_rx_done cycle = N; o_tx_start asserted at cycle N+2.
- i_rx_done in EXEC, SEND or WAIT_TX: byte dropped, no register change; next frame starts only after return to WAIT_OP.
- i_tx_done outside WAIT_TX: ignored.
- o_busy, o_tx_start, o_timeout_err decoded from registered state (no combinational path from inputs).
- Reset mid-frame or mid-transmission: immediate return to reset values; any pending transmission abandoned, no o_tx_start issued.
- o_alu_a/b/op change only on accepted bytes; o_tx_data changes only at EXEC.

Test Plan:
- Basic frame: rx bytes 0x20, 0x05, 0x03, ALU model ADD -> o_alu_op=6'h20, a=0x05, b=0x03; o_tx_start one pulse 2 cycles after third rx_done with o_tx_data=0x08; after i_tx_done, o_busy=0.
- Opcode masking: first byte 0xE2 -> o_alu_op=6'h22; frame 0xE2,0x0F,0x05 with SUB model -> o_tx_data=0x0A.
- Timeout (TIMEOUT_CYCLES=16 in bench): send 0x20, 0x05, then idle -> o_timeout_err single pulse 16 cycles after second rx_done, state WAIT_OP, no o_tx_start; next full frame 0x24,0xF0,0x3C (AND) -> o_tx_data=0x30.
- Timeout boundary: rx_done arrives exactly on the cycle counter reaches TIMEOUT_CYCLES-1 -> byte accepted, no o_timeout_err.
- Busy drop: rx_done with 0x55 while in WAIT_TX -> ignored; o_alu_* unchanged; subsequent frame processed normally after i_tx_done.
- Reset mid-frame: assert i_reset in WAIT_TX -> all outputs zero, o_busy=0, no o_tx_start afterwards; later i_tx_done ignored.
